// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports (instruction fetch "if_*" and data "dm_*")
// and the shared memory port of the memory port arbiter.
//
// Signals:
//   if_req_i / if_addr_i            fetch request and address
//   if_ack_o / if_rdata_o           fetch completion pulse and fetched word
//   dm_req_i / dm_we_i / dm_addr_i  data request, direction and address
//   dm_wdata_i                      data write word
//   dm_ack_o / dm_rdata_o           data completion pulse and read word
//   err_o                           timeout indication, coincident with an ack
//   mem_req_o / mem_we_o            memory transaction active / write enable
//   mem_addr_o / mem_wdata_o        memory address / write data
//   mem_rdata_i / mem_ready_i       memory read data / one-cycle completion
//
// Modports:
//   slave  - the arbiter's view (drives acks, rdata, err and mem_* outputs)
//   master - the environment's view (requesters plus memory model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output if_ack_o, if_rdata_o,
        output dm_ack_o, dm_rdata_o,
        output err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  if_ack_o, if_rdata_o,
        input  dm_ack_o, dm_rdata_o,
        input  err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester and a data requester. The data port normally wins ties, but after
// STARVE_LIMIT back-to-back data grants made while a fetch was waiting, the
// fetch port gets the next tie. A transaction the memory never completes is
// aborted after TIMEOUT busy cycles with an ack plus err_o.
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - mem_port_arbiter_if.slave carrying both requester ports and the
//            memory port (see the interface file for the signal list)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] dm_streak;
    logic [7:0] wait_count;

    logic if_eligible;
    logic dm_eligible;
    logic grant_if;
    logic grant_dm;
    logic complete;
    logic timed_out;

    // A port is never re-granted in the cycle its own ack is showing, even
    // though its requester may still be holding req high at that point.
    assign if_eligible = bus.if_req_i && !bus.if_ack_o;
    assign dm_eligible = bus.dm_req_i && !bus.dm_ack_o;

    // Next-state and grant/completion decode. Grants only happen in IDLE;
    // the busy states always return to IDLE, so every grant is separated by
    // at least one idle (ack) cycle. A ready in the final allowed busy cycle
    // wins over the timeout.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (if_eligible && dm_eligible) begin
                    if (dm_streak == STREAK_MAX) begin
                        grant_if = 1'b1;
                    end else begin
                        grant_dm = 1'b1;
                    end
                end else if (if_eligible) begin
                    grant_if = 1'b1;
                end else if (dm_eligible) begin
                    grant_dm = 1'b1;
                end
                if (grant_if) begin
                    state_next = BUSY_IF;
                end else if (grant_dm) begin
                    state_next = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (bus.mem_ready_i) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wait_count == WAIT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered datapath: latches the winner's request onto the memory
    // port, produces the one-cycle ack/err pulses, captures read data, and
    // maintains the starvation streak and busy wait counter. A reset while
    // busy simply drops the transaction; any late ready lands in IDLE and
    // is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.if_ack_o    <= 1'b0;
            bus.dm_ack_o    <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.if_rdata_o  <= '0;
            bus.dm_rdata_o  <= '0;
            dm_streak       <= '0;
            wait_count      <= '0;
        end else begin
            bus.if_ack_o <= 1'b0;
            bus.dm_ack_o <= 1'b0;
            bus.err_o    <= 1'b0;

            if (grant_if) begin
                bus.mem_req_o  <= 1'b1;
                bus.mem_we_o   <= 1'b0;
                bus.mem_addr_o <= bus.if_addr_i;
                wait_count     <= '0;
                dm_streak      <= '0;
            end else if (grant_dm) begin
                bus.mem_req_o   <= 1'b1;
                bus.mem_we_o    <= bus.dm_we_i;
                bus.mem_addr_o  <= bus.dm_addr_i;
                bus.mem_wdata_o <= bus.dm_wdata_i;
                wait_count      <= '0;
                // The streak only grows while a fetch is actually waiting.
                if (!bus.if_req_i) begin
                    dm_streak <= '0;
                end else if (dm_streak != STREAK_MAX) begin
                    dm_streak <= dm_streak + 4'd1;
                end
            end

            if (complete || timed_out) begin
                bus.mem_req_o <= 1'b0;
                bus.err_o     <= timed_out;
                if (state == BUSY_IF) begin
                    bus.if_ack_o <= 1'b1;
                    if (complete) begin
                        bus.if_rdata_o <= bus.mem_rdata_i;
                    end
                end else begin
                    bus.dm_ack_o <= 1'b1;
                    if (complete) begin
                        bus.dm_rdata_o <= bus.mem_rdata_i;
                    end
                end
            end else if (state != IDLE) begin
                wait_count <= wait_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model (who owns the memory, how many busy cycles have elapsed, which acks
// are due) predicts every output each cycle; directed scenarios come first,
// followed by randomized requesters and a randomized memory responder.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 2;
    localparam int TIMEOUT      = 4;
    localparam int NONE = 0;
    localparam int PIF  = 1;
    localparam int PDM  = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus values applied at the next rising edge.
    logic        rst_in;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    // Reference model: the outstanding transaction and the expected outputs.
    int          owner;
    int          busy_done;
    int          streak;
    int          planned_lat;
    logic [31:0] txn_addr, txn_wdata;
    logic        txn_we;
    logic        exp_if_ack, exp_dm_ack, exp_err;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    logic        dm_rdata_known;
    int          grant_log[$];
    int          exp_order[6] = '{PDM, PDM, PIF, PDM, PDM, PIF};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_model();
        checkOutput("if_ack", 32'(bus.if_ack_o), 32'(exp_if_ack));
        checkOutput("dm_ack", 32'(bus.dm_ack_o), 32'(exp_dm_ack));
        checkOutput("err", 32'(bus.err_o), 32'(exp_err));
        checkOutput("mem_req", 32'(bus.mem_req_o), 32'(owner != NONE));
        if (owner != NONE) begin
            checkOutput("mem_addr", bus.mem_addr_o, txn_addr);
            checkOutput("mem_we", 32'(bus.mem_we_o), 32'(txn_we));
            if (owner == PDM) begin
                checkOutput("mem_wdata", bus.mem_wdata_o, txn_wdata);
            end
        end
        checkOutput("if_rdata", bus.if_rdata_o, exp_if_rdata);
        if (dm_rdata_known) begin
            checkOutput("dm_rdata", bus.dm_rdata_o, exp_dm_rdata);
        end
    endtask

    // Drive the pending stimulus, advance the model across the coming edge,
    // then let the edge happen and settle 1ns past it.
    task automatic applyStimulus();
        logic n_if_ack, n_dm_ack, n_err, if_elig, dm_elig;
        int   winner;
        n_if_ack = 1'b0;
        n_dm_ack = 1'b0;
        n_err    = 1'b0;
        rst_i           = rst_in;
        bus.if_req_i    = if_req;
        bus.if_addr_i   = if_addr;
        bus.dm_req_i    = dm_req;
        bus.dm_we_i     = dm_we;
        bus.dm_addr_i   = dm_addr;
        bus.dm_wdata_i  = dm_wdata;
        bus.mem_ready_i = mem_ready;
        bus.mem_rdata_i = mem_rdata;
        if (rst_in) begin
            owner          = NONE;
            streak         = 0;
            exp_if_rdata   = '0;
            exp_dm_rdata   = '0;
            dm_rdata_known = 1'b1;
        end else if (owner != NONE) begin
            if (mem_ready || (busy_done + 1 == TIMEOUT)) begin
                if (owner == PIF) n_if_ack = 1'b1;
                else              n_dm_ack = 1'b1;
                n_err = !mem_ready;
                if (mem_ready) begin
                    if (owner == PIF) begin
                        exp_if_rdata = mem_rdata;
                    end else if (txn_we) begin
                        dm_rdata_known = 1'b0;
                    end else begin
                        exp_dm_rdata   = mem_rdata;
                        dm_rdata_known = 1'b1;
                    end
                end
                owner = NONE;
            end else begin
                busy_done++;
            end
        end else begin
            if_elig = if_req && !exp_if_ack;
            dm_elig = dm_req && !exp_dm_ack;
            winner  = NONE;
            if (if_elig && dm_elig) winner = (streak == STARVE_LIMIT) ? PIF : PDM;
            else if (if_elig)       winner = PIF;
            else if (dm_elig)       winner = PDM;
            if (winner == PIF) begin
                txn_addr = if_addr;
                txn_we   = 1'b0;
                streak   = 0;
            end else if (winner == PDM) begin
                txn_addr  = dm_addr;
                txn_we    = dm_we;
                txn_wdata = dm_wdata;
                streak    = if_req ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
            end
            if (winner != NONE) begin
                owner     = winner;
                busy_done = 0;
                grant_log.push_back(winner);
            end
        end
        exp_if_ack = n_if_ack;
        exp_dm_ack = n_dm_ack;
        exp_err    = n_err;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_cycle();
        check_model();
        applyStimulus();
    endtask

    initial begin
        rst_in = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        owner = NONE; busy_done = 0; streak = 0; planned_lat = 0;
        txn_addr = '0; txn_wdata = '0; txn_we = 0;
        exp_if_ack = 0; exp_dm_ack = 0; exp_err = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0; dm_rdata_known = 1'b1;

        // Reset state.
        applyStimulus();
        applyStimulus();
        check_model();
        checkOutput("rst_mem_addr", bus.mem_addr_o, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        checkOutput("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        rst_in = 1'b0;
        step_cycle();

        // Fetch-only read, ready arriving in the last allowed busy cycle.
        if_req = 1; if_addr = 32'h10;
        step_cycle();
        checkOutput("ifrd_mem_req", 32'(bus.mem_req_o), 32'h1);
        checkOutput("ifrd_mem_addr", bus.mem_addr_o, 32'h10);
        checkOutput("ifrd_mem_we", 32'(bus.mem_we_o), 32'h0);
        mem_rdata = 32'hDEADBEEF;
        repeat (3) step_cycle();
        mem_ready = 1;
        step_cycle();
        mem_ready = 0; if_req = 0;
        checkOutput("ifrd_ack", 32'(bus.if_ack_o), 32'h1);
        checkOutput("ifrd_rdata", bus.if_rdata_o, 32'hDEADBEEF);
        checkOutput("ifrd_err", 32'(bus.err_o), 32'h0);
        step_cycle();
        checkOutput("ifrd_ack_single", 32'(bus.if_ack_o), 32'h0);

        // Simultaneous requests: data write first, then the fetch.
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h5;
        step_cycle();
        checkOutput("sim_dm_addr", bus.mem_addr_o, 32'h40);
        checkOutput("sim_dm_we", 32'(bus.mem_we_o), 32'h1);
        checkOutput("sim_dm_wdata", bus.mem_wdata_o, 32'h5);
        mem_ready = 1;
        step_cycle();
        mem_ready = 0; dm_req = 0;
        checkOutput("sim_dm_ack_lat2", 32'(bus.dm_ack_o), 32'h1);
        checkOutput("sim_if_ack_low", 32'(bus.if_ack_o), 32'h0);
        step_cycle();
        checkOutput("sim_if_addr", bus.mem_addr_o, 32'h20);
        checkOutput("sim_if_we", 32'(bus.mem_we_o), 32'h0);
        mem_ready = 1; mem_rdata = 32'h12345678;
        step_cycle();
        mem_ready = 0; if_req = 0;
        checkOutput("sim_if_ack", 32'(bus.if_ack_o), 32'h1);
        checkOutput("sim_if_rdata", bus.if_rdata_o, 32'h12345678);
        step_cycle();
        checkOutput("sim_idle", 32'(bus.mem_req_o), 32'h0);

        // A request still held in its ack cycle must not be re-granted.
        dm_req = 1; dm_we = 0; dm_addr = 32'h80;
        step_cycle();
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        step_cycle();
        mem_ready = 0;
        checkOutput("hold_dm_ack", 32'(bus.dm_ack_o), 32'h1);
        checkOutput("hold_dm_rdata", bus.dm_rdata_o, 32'hCAFEF00D);
        step_cycle();
        checkOutput("hold_no_regrant", 32'(bus.mem_req_o), 32'h0);
        dm_req = 0;
        step_cycle();

        // Timeout: memory never answers.
        dm_req = 1; dm_we = 0; dm_addr = 32'hC0;
        step_cycle();
        repeat (4) step_cycle();
        checkOutput("tmo_dm_ack", 32'(bus.dm_ack_o), 32'h1);
        checkOutput("tmo_err", 32'(bus.err_o), 32'h1);
        checkOutput("tmo_mem_req", 32'(bus.mem_req_o), 32'h0);
        checkOutput("tmo_rdata_kept", bus.dm_rdata_o, 32'hCAFEF00D);
        dm_req = 0;
        step_cycle();
        checkOutput("tmo_err_single", 32'(bus.err_o), 32'h0);

        // Starvation: the fetch requester drops its request during each data
        // ack cycle, so data wins STARVE_LIMIT ties before the fetch gets one.
        grant_log.delete();
        dm_req = 1; dm_we = 1; dm_wdata = 32'h99; if_req = 1; if_addr = 32'h100;
        for (int i = 0; i < 40 && grant_log.size() < 6; i++) begin
            mem_ready = (owner != NONE);
            if_req    = !exp_dm_ack;
            if (exp_dm_ack) dm_addr = dm_addr + 32'h4;
            step_cycle();
        end
        checkOutput("starve_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("starve_order%0d", i),
                        32'((grant_log.size() > i) ? grant_log[i] : NONE), 32'(exp_order[i]));
        end
        dm_req = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (owner != NONE);
            if (exp_if_ack) if_req = 0;
            step_cycle();
        end
        if_req = 0; mem_ready = 0;
        step_cycle();

        // Reset in the middle of a data transaction, then a late ready.
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h77;
        step_cycle();
        step_cycle();
        rst_in = 1; dm_req = 0;
        step_cycle();
        rst_in = 0; mem_ready = 1;
        step_cycle();
        mem_ready = 0;
        checkOutput("rstb_dm_ack", 32'(bus.dm_ack_o), 32'h0);
        checkOutput("rstb_mem_req", 32'(bus.mem_req_o), 32'h0);
        checkOutput("rstb_mem_addr", bus.mem_addr_o, 32'h0);
        checkOutput("rstb_mem_wdata", bus.mem_wdata_o, 32'h0);
        checkOutput("rstb_dm_rdata", bus.dm_rdata_o, 32'h0);
        if_req = 1; if_addr = 32'h300;
        step_cycle();
        checkOutput("rstb_if_addr", bus.mem_addr_o, 32'h300);
        mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
        step_cycle();
        mem_ready = 0; if_req = 0;
        checkOutput("rstb_if_ack", 32'(bus.if_ack_o), 32'h1);
        step_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst_in    = ($urandom_range(0, 399) == 0);
            mem_rdata = $urandom;
            if (owner != NONE) begin
                if (busy_done == 0) planned_lat = $urandom_range(0, 5);
                mem_ready = (busy_done == planned_lat);
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            if (exp_if_ack) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom;
            end
            if (exp_dm_ack) begin
                dm_req   = 1'($urandom_range(0, 1));
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            step_cycle();
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
